// File: rtl/fault_injector.sv
// ---------------------------------------------------------------------------
// fault_pkg / fault_injector
//
// Purpose:
//   Runtime fault-injection engine. A table of programmable slots (one fault
//   configuration each) is loaded while idle. Once armed, a free-running
//   cycle counter is compared against every slot's trigger cycle. The
//   lowest-index eligible slot fires, and its fault is applied to the
//   datapath hooks for max(duration,1) cycles. Live status is reported back.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg_valid/cfg_ready slot write handshake (ready only while idle)
//   cfg_idx, cfg_data   target slot and its new contents
//   arm, disarm         pulses: (re)start the schedule / abort to idle
//   flt_*               fault strobes and parameters into the datapath
//   status              active flag, current fault, cycles left, injections
//   cycle_cnt           current value of the schedule counter
// ---------------------------------------------------------------------------
package fault_pkg;

    localparam int MAX_FAULT_CONFIGS = 8;
    localparam int FAULT_FIELD_W     = 32;

    typedef enum logic [3:0] {
        FAULT_NONE         = 4'd0,
        FAULT_BACKPRESSURE = 4'd1,
        FAULT_FIFO_FULL    = 4'd2,
        FAULT_KILL         = 4'd3,
        FAULT_CORRUPT      = 4'd4,
        FAULT_STRETCH      = 4'd5,
        FAULT_BURST        = 4'd6,
        FAULT_REORDER      = 4'd7,
        FAULT_RESET        = 4'd8
    } fault_type_e;

    // fault_type is a raw field so that undefined encodings can be carried
    // on the write port and rejected by the engine.
    typedef struct packed {
        logic [3:0]               fault_type;
        logic [FAULT_FIELD_W-1:0] trigger_cycle;
        logic [FAULT_FIELD_W-1:0] duration_cycles;
        logic [FAULT_FIELD_W-1:0] param;
    } fault_config_t;

    typedef struct packed {
        logic                     active;
        fault_type_e              current_fault;
        logic [FAULT_FIELD_W-1:0] cycles_remaining;
        logic [FAULT_FIELD_W-1:0] injections_count;
    } fault_status_t;

endpackage

module fault_injector
    import fault_pkg::*;
#(
    parameter  int NUM_CFG = MAX_FAULT_CONFIGS,
    // Must match the width of the fault_config_t fields.
    parameter  int CNT_W   = FAULT_FIELD_W,
    localparam int IDX_W   = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  fault_config_t        cfg_data,
    input  logic                 arm,
    input  logic                 disarm,
    output logic                 flt_backpressure,
    output logic                 flt_fifo_full,
    output logic                 flt_kill,
    output logic [31:0]          flt_corrupt_mask,
    output logic [31:0]          flt_stretch,
    output logic                 flt_burst_start,
    output logic [31:0]          flt_burst_size,
    output logic [31:0]          flt_reorder_disp,
    output logic                 flt_reset_rec,
    output fault_status_t        status,
    output logic [CNT_W-1:0]     cycle_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    state_e             state_q,       state_d;
    logic [CNT_W-1:0]   cnt_q,         cnt_d;
    logic [NUM_CFG-1:0] slot_valid_q,  slot_valid_d;
    logic [NUM_CFG-1:0] fired_q,       fired_d;
    fault_config_t      slot_cfg_q [NUM_CFG];
    fault_config_t      slot_cfg_d [NUM_CFG];
    fault_type_e        act_type_q,    act_type_d;
    logic [31:0]        act_param_q,   act_param_d;
    logic [31:0]        remaining_q,   remaining_d;
    logic [31:0]        inj_cnt_q,     inj_cnt_d;
    logic               first_q,       first_d;

    logic [CNT_W-1:0]   cnt_next;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;

    assign cfg_ready = (state_q == ST_IDLE);
    assign cycle_cnt = cnt_q;

    // Saturating increment so a long run never wraps back to early triggers.
    assign cnt_next = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    // Lowest-index eligible slot; scanning downward lets the lowest index
    // overwrite any higher match.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = NUM_CFG - 1; i >= 0; i--) begin
            if (slot_valid_q[i] && !fired_q[i] &&
                (slot_cfg_q[i].trigger_cycle <= cnt_q)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        slot_valid_d = slot_valid_q;
        fired_d      = fired_q;
        slot_cfg_d   = slot_cfg_q;
        act_type_d   = act_type_q;
        act_param_d  = act_param_q;
        remaining_d  = remaining_q;
        inj_cnt_d    = inj_cnt_q;
        first_d      = 1'b0;

        // Slot table writes are only possible while idle.
        if (cfg_valid && (state_q == ST_IDLE)) begin
            if (cfg_data.fault_type == FAULT_NONE) begin
                slot_valid_d[cfg_idx] = 1'b0;
                fired_d[cfg_idx]      = 1'b0;
            end else if (cfg_data.fault_type <= FAULT_RESET) begin
                slot_valid_d[cfg_idx] = 1'b1;
                fired_d[cfg_idx]      = 1'b0;
                slot_cfg_d[cfg_idx]   = cfg_data;
            end
        end

        // disarm outranks arm; arm from any state restarts the schedule.
        if (disarm) begin
            state_d = ST_IDLE;
        end else if (arm) begin
            state_d = ST_ARMED;
            cnt_d   = '0;
            fired_d = '0;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    cnt_d = cnt_next;
                    if (sel_found) begin
                        state_d          = ST_ACTIVE;
                        fired_d[sel_idx] = 1'b1;
                        act_type_d       = fault_type_e'(slot_cfg_q[sel_idx].fault_type);
                        act_param_d      = slot_cfg_q[sel_idx].param;
                        // Zero duration is treated as a single cycle.
                        remaining_d      = (slot_cfg_q[sel_idx].duration_cycles == '0) ?
                                           '0 : slot_cfg_q[sel_idx].duration_cycles - 32'd1;
                        inj_cnt_d        = (inj_cnt_q == '1) ? inj_cnt_q : inj_cnt_q + 32'd1;
                        first_d          = 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    cnt_d = cnt_next;
                    // Returning to ARMED forces a one-cycle gap before the
                    // next selection.
                    if (remaining_q == '0) begin
                        state_d = ST_ARMED;
                    end else begin
                        remaining_d = remaining_q - 32'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            slot_valid_q <= '0;
            fired_q      <= '0;
            slot_cfg_q   <= '{default: '0};
            act_type_q   <= FAULT_NONE;
            act_param_q  <= '0;
            remaining_q  <= '0;
            inj_cnt_q    <= '0;
            first_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            slot_valid_q <= slot_valid_d;
            fired_q      <= fired_d;
            slot_cfg_q   <= slot_cfg_d;
            act_type_q   <= act_type_d;
            act_param_q  <= act_param_d;
            remaining_q  <= remaining_d;
            inj_cnt_q    <= inj_cnt_d;
            first_q      <= first_d;
        end
    end

    // Outputs decode purely from registered state, so an asynchronous reset
    // drops every strobe immediately. Only the active fault's group is driven.
    always_comb begin
        flt_backpressure = 1'b0;
        flt_fifo_full    = 1'b0;
        flt_kill         = 1'b0;
        flt_corrupt_mask = '0;
        flt_stretch      = '0;
        flt_burst_start  = 1'b0;
        flt_burst_size   = '0;
        flt_reorder_disp = '0;
        flt_reset_rec    = 1'b0;
        if (state_q == ST_ACTIVE) begin
            case (act_type_q)
                FAULT_BACKPRESSURE: flt_backpressure = 1'b1;
                FAULT_FIFO_FULL:    flt_fifo_full    = 1'b1;
                FAULT_KILL:         flt_kill         = 1'b1;
                FAULT_CORRUPT:      flt_corrupt_mask = act_param_q;
                FAULT_STRETCH:      flt_stretch      = act_param_q;
                FAULT_BURST: begin
                    flt_burst_start = first_q;
                    flt_burst_size  = act_param_q;
                end
                FAULT_REORDER:      flt_reorder_disp = act_param_q;
                FAULT_RESET:        flt_reset_rec    = first_q;
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        status                  = '0;
        status.current_fault    = FAULT_NONE;
        status.injections_count = inj_cnt_q;
        if (state_q == ST_ACTIVE) begin
            status.active           = 1'b1;
            status.current_fault    = act_type_q;
            status.cycles_remaining = remaining_q;
        end
    end

endmodule

// File: tb/tb_fault_injector.sv
// ---------------------------------------------------------------------------
// tb_fault_injector
//
// Directed scenarios plus randomized slot tables for fault_injector. The
// random scenarios are checked against a schedule model: from the slot table
// it derives the list of fault windows (first output cycle, length, slot) and
// the expected outputs at every counter value follow from that list.
// ---------------------------------------------------------------------------
module tb_fault_injector;
    import fault_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [2:0]    cfg_idx;
    fault_config_t cfg_data;
    logic          arm;
    logic          disarm;
    logic          flt_backpressure;
    logic          flt_fifo_full;
    logic          flt_kill;
    logic [31:0]   flt_corrupt_mask;
    logic [31:0]   flt_stretch;
    logic          flt_burst_start;
    logic [31:0]   flt_burst_size;
    logic [31:0]   flt_reorder_disp;
    logic          flt_reset_rec;
    fault_status_t status;
    logic [31:0]   cycle_cnt;

    logic [132:0]  obs_vec;

    int n_cmp = 0;
    int n_bad = 0;

    // Slot table model and derived fault windows.
    bit          m_valid [8];
    logic [3:0]  m_type  [8];
    int          m_trig  [8];
    int          m_dur   [8];
    logic [31:0] m_param [8];
    int          w_start [$];
    int          w_len   [$];
    int          w_idx   [$];
    int unsigned inj_exp = 0;

    always #5 clk = ~clk;

    fault_injector #(.NUM_CFG(8), .CNT_W(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_idx          (cfg_idx),
        .cfg_data         (cfg_data),
        .arm              (arm),
        .disarm           (disarm),
        .flt_backpressure (flt_backpressure),
        .flt_fifo_full    (flt_fifo_full),
        .flt_kill         (flt_kill),
        .flt_corrupt_mask (flt_corrupt_mask),
        .flt_stretch      (flt_stretch),
        .flt_burst_start  (flt_burst_start),
        .flt_burst_size   (flt_burst_size),
        .flt_reorder_disp (flt_reorder_disp),
        .flt_reset_rec    (flt_reset_rec),
        .status           (status),
        .cycle_cnt        (cycle_cnt)
    );

    assign obs_vec = {flt_backpressure, flt_fifo_full, flt_kill, flt_corrupt_mask,
                      flt_stretch, flt_burst_start, flt_burst_size,
                      flt_reorder_disp, flt_reset_rec};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_slot(input int idx, input logic [3:0] ty, input int trig,
                              input int dur, input logic [31:0] pa);
        cfg_valid                = 1'b1;
        cfg_idx                  = 3'(idx);
        cfg_data.fault_type      = ty;
        cfg_data.trigger_cycle   = 32'(trig);
        cfg_data.duration_cycles = 32'(dur);
        cfg_data.param           = pa;
        tick();
        cfg_valid = 1'b0;
        if (ty == 4'd0) begin
            m_valid[idx] = 1'b0;
        end else if (ty <= 4'd8) begin
            m_valid[idx] = 1'b1;
            m_type[idx]  = ty;
            m_trig[idx]  = trig;
            m_dur[idx]   = dur;
            m_param[idx] = pa;
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic pulse_disarm();
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
    endtask

    // Each fault starts at the earliest counter value where both the engine
    // is free and some unfired slot has reached its trigger; ties go to the
    // lowest index. Outputs begin one cycle later, last max(dur,1) cycles, and
    // the engine is free again after one further gap cycle.
    function automatic void build_schedule();
        bit done [8];
        int free_at = 0;
        for (int i = 0; i < 8; i++) done[i] = 1'b0;
        w_start.delete();
        w_len.delete();
        w_idx.delete();
        forever begin
            int t_min = 32'h7fffffff;
            int sel_t;
            int pick = -1;
            int len;
            for (int i = 0; i < 8; i++)
                if (m_valid[i] && !done[i] && m_trig[i] < t_min) t_min = m_trig[i];
            if (t_min == 32'h7fffffff) break;
            sel_t = (t_min > free_at) ? t_min : free_at;
            for (int i = 7; i >= 0; i--)
                if (m_valid[i] && !done[i] && m_trig[i] <= sel_t) pick = i;
            done[pick] = 1'b1;
            len = (m_dur[pick] == 0) ? 1 : m_dur[pick];
            w_start.push_back(sel_t + 1);
            w_len.push_back(len);
            w_idx.push_back(pick);
            free_at = sel_t + len + 1;
        end
    endfunction

    function automatic logic [132:0] out_vec_for(input logic [3:0] ty, input logic [31:0] pa,
                                                 input bit first);
        logic        bp = 1'b0, ff = 1'b0, kl = 1'b0, bs = 1'b0, rr = 1'b0;
        logic [31:0] cm = '0, st = '0, bz = '0, rd = '0;
        case (ty)
            4'd1: bp = 1'b1;
            4'd2: ff = 1'b1;
            4'd3: kl = 1'b1;
            4'd4: cm = pa;
            4'd5: st = pa;
            4'd6: begin bs = first; bz = pa; end
            4'd7: rd = pa;
            4'd8: rr = first;
            default: ;
        endcase
        return {bp, ff, kl, cm, st, bs, bz, rd, rr};
    endfunction

    task automatic test_reset();
        n_cmp++;
        if (obs_vec !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset_outputs got=%h exp=0", obs_vec);
        end
        n_cmp++;
        if (status !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset_status got=%h exp=0", status);
        end
        n_cmp++;
        if (cycle_cnt !== 32'd0 || cfg_ready !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL reset_cnt_ready got cnt=%0d ready=%b exp cnt=0 ready=1",
                     cycle_cnt, cfg_ready);
        end
    endtask

    task automatic test_backpressure();
        int bp_cycles = 0;
        write_slot(0, 4'd1, 10, 5, 32'd0);
        pulse_arm();
        for (int t = 0; t <= 20; t++) begin
            n_cmp++;
            if (flt_backpressure !== (t >= 11 && t <= 15)) begin
                n_bad++;
                $display("[TB] FAIL bp_level t=%0d got=%b exp=%b", t, flt_backpressure,
                         (t >= 11 && t <= 15));
            end
            n_cmp++;
            if (cycle_cnt !== 32'(t)) begin
                n_bad++;
                $display("[TB] FAIL bp_cycle_cnt got=%0d exp=%0d", cycle_cnt, t);
            end
            if (flt_backpressure === 1'b1) bp_cycles++;
            tick();
        end
        inj_exp++;
        n_cmp++;
        if (bp_cycles != 5) begin
            n_bad++;
            $display("[TB] FAIL bp_length got=%0d exp=5", bp_cycles);
        end
        n_cmp++;
        if (status.injections_count !== 32'(inj_exp)) begin
            n_bad++;
            $display("[TB] FAIL bp_inj got=%0d exp=%0d", status.injections_count, inj_exp);
        end
        pulse_disarm();
        write_slot(0, 4'd0, 0, 0, 32'd0);
    endtask

    task automatic test_overlap();
        write_slot(1, 4'd4, 3, 2, 32'hA5);
        write_slot(2, 4'd8, 3, 0, 32'd0);
        pulse_arm();
        for (int t = 0; t <= 10; t++) begin
            logic [31:0] exp_mask;
            exp_mask = (t == 4 || t == 5) ? 32'hA5 : 32'd0;
            n_cmp++;
            if (flt_corrupt_mask !== exp_mask) begin
                n_bad++;
                $display("[TB] FAIL ovl_mask t=%0d got=%h exp=%h", t, flt_corrupt_mask, exp_mask);
            end
            n_cmp++;
            if (flt_reset_rec !== (t == 7)) begin
                n_bad++;
                $display("[TB] FAIL ovl_reset_rec t=%0d got=%b exp=%b", t, flt_reset_rec, (t == 7));
            end
            n_cmp++;
            if (status.active !== (t == 4 || t == 5 || t == 7)) begin
                n_bad++;
                $display("[TB] FAIL ovl_active t=%0d got=%b", t, status.active);
            end
            tick();
        end
        inj_exp += 2;
        n_cmp++;
        if (status.injections_count !== 32'(inj_exp)) begin
            n_bad++;
            $display("[TB] FAIL ovl_inj got=%0d exp=%0d", status.injections_count, inj_exp);
        end
        pulse_disarm();
        write_slot(1, 4'd0, 0, 0, 32'd0);
        write_slot(2, 4'd0, 0, 0, 32'd0);
    endtask

    task automatic test_burst();
        write_slot(0, 4'd6, 0, 4, 32'd16);
        pulse_arm();
        for (int t = 0; t <= 6; t++) begin
            bit in_win;
            in_win = (t >= 1 && t <= 4);
            n_cmp++;
            if (flt_burst_start !== (t == 1)) begin
                n_bad++;
                $display("[TB] FAIL burst_start t=%0d got=%b exp=%b", t, flt_burst_start, (t == 1));
            end
            n_cmp++;
            if (flt_burst_size !== (in_win ? 32'd16 : 32'd0)) begin
                n_bad++;
                $display("[TB] FAIL burst_size t=%0d got=%0d", t, flt_burst_size);
            end
            n_cmp++;
            if (status.cycles_remaining !== (in_win ? 32'(4 - t) : 32'd0)) begin
                n_bad++;
                $display("[TB] FAIL burst_remaining t=%0d got=%0d", t, status.cycles_remaining);
            end
            tick();
        end
        inj_exp++;
        pulse_disarm();
        write_slot(0, 4'd0, 0, 0, 32'd0);
    endtask

    task automatic test_disarm();
        write_slot(0, 4'd3, 0, 100, 32'd0);
        pulse_arm();
        for (int t = 0; t < 20; t++) begin
            n_cmp++;
            if (flt_kill !== (t >= 1)) begin
                n_bad++;
                $display("[TB] FAIL kill_level t=%0d got=%b exp=%b", t, flt_kill, (t >= 1));
            end
            tick();
        end
        n_cmp++;
        if (flt_kill !== 1'b1 || status.cycles_remaining !== 32'd80) begin
            n_bad++;
            $display("[TB] FAIL kill_before_disarm got kill=%b rem=%0d exp kill=1 rem=80",
                     flt_kill, status.cycles_remaining);
        end
        inj_exp++;
        pulse_disarm();
        n_cmp++;
        if (flt_kill !== 1'b0 || status.active !== 1'b0 || cfg_ready !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL disarm_drop got kill=%b active=%b ready=%b exp 0 0 1",
                     flt_kill, status.active, cfg_ready);
        end
        n_cmp++;
        if (cycle_cnt !== 32'd20) begin
            n_bad++;
            $display("[TB] FAIL disarm_cnt_hold got=%0d exp=20", cycle_cnt);
        end
        // Simultaneous arm and disarm must leave the engine idle.
        arm    = 1'b1;
        disarm = 1'b1;
        tick();
        arm    = 1'b0;
        disarm = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (flt_kill !== 1'b0 || cycle_cnt !== 32'd20 || cfg_ready !== 1'b1) begin
                n_bad++;
                $display("[TB] FAIL arm_disarm_idle got kill=%b cnt=%0d ready=%b exp 0 20 1",
                         flt_kill, cycle_cnt, cfg_ready);
            end
            tick();
        end
        // Undefined encoding must leave the KILL slot untouched.
        write_slot(0, 4'b1010, 5, 1, 32'd0);
        pulse_arm();
        tick();
        n_cmp++;
        if (flt_kill !== 1'b1 || status.current_fault !== FAULT_KILL ||
            status.cycles_remaining !== 32'd99) begin
            n_bad++;
            $display("[TB] FAIL bad_type_ignored got kill=%b fault=%0d rem=%0d exp 1 3 99",
                     flt_kill, status.current_fault, status.cycles_remaining);
        end
        inj_exp++;
        pulse_disarm();
        write_slot(0, 4'd0, 0, 0, 32'd0);
    endtask

    task automatic test_rearm();
        write_slot(0, 4'd5, 2, 1, 32'd7);
        pulse_arm();
        n_cmp++;
        if (cfg_ready !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL armed_ready got=%b exp=0", cfg_ready);
        end
        // A write attempt while armed must be ignored.
        cfg_valid = 1'b1;
        cfg_idx   = 3'd0;
        cfg_data  = '0;
        tick();
        cfg_valid = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            n_cmp++;
            if (flt_stretch !== ((t == 3) ? 32'd7 : 32'd0)) begin
                n_bad++;
                $display("[TB] FAIL stretch_first t=%0d got=%0d", t, flt_stretch);
            end
            tick();
        end
        inj_exp++;
        pulse_arm();
        for (int t = 0; t <= 5; t++) begin
            n_cmp++;
            if (flt_stretch !== ((t == 3) ? 32'd7 : 32'd0)) begin
                n_bad++;
                $display("[TB] FAIL stretch_rearm t=%0d got=%0d", t, flt_stretch);
            end
            tick();
        end
        inj_exp++;
        n_cmp++;
        if (status.injections_count !== 32'(inj_exp)) begin
            n_bad++;
            $display("[TB] FAIL rearm_inj got=%0d exp=%0d", status.injections_count, inj_exp);
        end
        pulse_disarm();
        // Restart while a fault is in progress.
        write_slot(0, 4'd2, 1, 10, 32'd0);
        pulse_arm();
        for (int t = 0; t < 3; t++) begin
            n_cmp++;
            if (flt_fifo_full !== (t >= 2)) begin
                n_bad++;
                $display("[TB] FAIL ff_before_restart t=%0d got=%b", t, flt_fifo_full);
            end
            tick();
        end
        inj_exp++;
        pulse_arm();
        n_cmp++;
        if (flt_fifo_full !== 1'b0 || status.active !== 1'b0 || cycle_cnt !== 32'd0) begin
            n_bad++;
            $display("[TB] FAIL restart_abort got ff=%b active=%b cnt=%0d exp 0 0 0",
                     flt_fifo_full, status.active, cycle_cnt);
        end
        for (int t = 0; t <= 4; t++) begin
            n_cmp++;
            if (flt_fifo_full !== (t >= 2)) begin
                n_bad++;
                $display("[TB] FAIL ff_after_restart t=%0d got=%b", t, flt_fifo_full);
            end
            tick();
        end
        inj_exp++;
        n_cmp++;
        if (status.injections_count !== 32'(inj_exp)) begin
            n_bad++;
            $display("[TB] FAIL restart_inj got=%0d exp=%0d", status.injections_count, inj_exp);
        end
        pulse_disarm();
        write_slot(0, 4'd0, 0, 0, 32'd0);
    endtask

    task automatic test_random();
        for (int iter = 0; iter < 6; iter++) begin
            int last_t;
            int unsigned inj_base;
            for (int i = 0; i < 8; i++) begin
                int r = $urandom_range(0, 9);
                logic [3:0] ty;
                if (r == 0)      ty = 4'd0;
                else if (r == 1) ty = 4'($urandom_range(9, 15));
                else             ty = 4'($urandom_range(1, 8));
                write_slot(i, ty, $urandom_range(0, 30), $urandom_range(0, 5), $urandom);
            end
            build_schedule();
            last_t = 5;
            foreach (w_start[k])
                if (w_start[k] + w_len[k] + 2 > last_t) last_t = w_start[k] + w_len[k] + 2;
            inj_base = inj_exp;
            pulse_arm();
            for (int t = 0; t <= last_t; t++) begin
                logic [132:0]  exp_vec = '0;
                fault_status_t exp_st  = '0;
                int            started = 0;
                exp_st.current_fault = FAULT_NONE;
                foreach (w_start[k]) begin
                    if (w_start[k] <= t) started++;
                    if (t >= w_start[k] && t < w_start[k] + w_len[k]) begin
                        exp_vec = out_vec_for(m_type[w_idx[k]], m_param[w_idx[k]], t == w_start[k]);
                        exp_st.active           = 1'b1;
                        exp_st.current_fault    = fault_type_e'(m_type[w_idx[k]]);
                        exp_st.cycles_remaining = 32'(w_start[k] + w_len[k] - 1 - t);
                    end
                end
                exp_st.injections_count = 32'(inj_base + started);
                n_cmp++;
                if (obs_vec !== exp_vec) begin
                    n_bad++;
                    $display("[TB] FAIL rand_outputs iter=%0d t=%0d got=%h exp=%h",
                             iter, t, obs_vec, exp_vec);
                end
                n_cmp++;
                if (status !== exp_st) begin
                    n_bad++;
                    $display("[TB] FAIL rand_status iter=%0d t=%0d got=%h exp=%h",
                             iter, t, status, exp_st);
                end
                n_cmp++;
                if (cycle_cnt !== 32'(t)) begin
                    n_bad++;
                    $display("[TB] FAIL rand_cycle_cnt iter=%0d got=%0d exp=%0d", iter, cycle_cnt, t);
                end
                tick();
            end
            inj_exp += w_start.size();
            pulse_disarm();
        end
    endtask

    task automatic test_async_reset();
        write_slot(0, 4'd3, 0, 50, 32'd0);
        pulse_arm();
        tick();
        tick();
        n_cmp++;
        if (flt_kill !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL async_pre_kill got=%b exp=1", flt_kill);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs_vec !== '0 || status !== '0 || cycle_cnt !== 32'd0) begin
            n_bad++;
            $display("[TB] FAIL async_reset got out=%h status=%h cnt=%0d exp all 0",
                     obs_vec, status, cycle_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired before the end of the run");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_idx   = '0;
        cfg_data  = '0;
        arm       = 1'b0;
        disarm    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_type[i]  = '0;
            m_trig[i]  = 0;
            m_dur[i]   = 0;
            m_param[i] = '0;
        end
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        test_backpressure();
        test_overlap();
        test_burst();
        test_disarm();
        test_rearm();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fault_injector.md
Name: fault_injector

Overview:
Runtime engine that consumes fault_config_t entries from fault_pkg and drives fault-enable strobes into the simulation datapath. Programmable slots are loaded over a valid/ready port and compared against a free-running cycle counter. On a trigger, the selected fault is applied for its duration, and a fault_status_t is reported back. It sits between the test harness/CSR layer and the datapath fault hooks (downstream ready gate, trace FIFO, kill switch, data path, sequencer, trace record emitter).

Parameters:
NUM_CFG, MAX_FAULT_CONFIGS (8), number of config slots
CNT_W, 32, cycle counter width; must equal fault_config_t field width

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
cfg_valid  in  1  slot write request
cfg_ready  out  1  high only in IDLE
cfg_idx  in  $clog2(NUM_CFG)  target slot
cfg_data  in  fault_config_t  slot contents
arm  in  1  pulse: clear counter and fired bits, enter ARMED
disarm  in  1  pulse: abort, enter IDLE
flt_backpressure  out  1  hold downstream ready low
flt_fifo_full  out  1  force trace FIFO full
flt_kill  out  1  assert kill switch
flt_corrupt_mask  out  32  XOR mask for data, 0 when inactive
flt_stretch  out  32  extra latency cycles, 0 when inactive
flt_burst_start  out  1  one-cycle pulse
flt_burst_size  out  32  burst transaction count
flt_reorder_disp  out  32  max seq_no displacement, 0 = no reorder
flt_reset_rec  out  1  one-cycle pulse: emit RESET record
status  out  fault_status_t  live status
cycle_cnt  out  CNT_W  current cycle counter

Behaviour:
- Reset: state IDLE, all slots invalid, fired bits clear, cycle_cnt 0. All outputs 0, status all-zero with current_fault=FAULT_NONE.
- Slot write: accepted when cfg_valid && cfg_ready; takes effect at that edge.
  - fault_type FAULT_NONE clears the slot's valid bit.
  - Encodings above FAULT_RESET (4'b1001..4'b1111) are ignored; the slot is unchanged.
  - Writing a slot clears its fired bit.
- States:
  - IDLE: counter held. arm -> ARMED, with cycle_cnt<=0 and all fired<=0.
  - ARMED: cycle_cnt increments each cycle, saturating at all-ones. A slot is eligible when valid && !fired && trigger_cycle <= cycle_cnt. If any slot is eligible, the lowest index wins: -> ACTIVE, that slot's fired<=1, injections_count+1 (saturating), cycles_remaining<=max(duration_cycles,1)-1.
  - ACTIVE: counter keeps running. Outputs for current_fault are driven from registered copies of type/parameter. When cycles_remaining==0 at the edge -> ARMED; otherwise decrement. There is a mandatory one-cycle ARMED gap between consecutive faults. Overlapping or late triggers fire after the gap, in index order; they are never dropped.
- Latency: outputs assert the first cycle after the selecting edge and remain for exactly max(duration,1) cycles.
- Pulse outputs: flt_burst_start and flt_reset_rec are high only in the first ACTIVE cycle, regardless of duration. flt_burst_size holds the parameter for the whole ACTIVE window.
- Level outputs: backpressure, fifo_full, kill, corrupt_mask, stretch and reorder_disp follow the ACTIVE window. All are 0 outside it.
- Fault-to-output mapping is exclusive: exactly one fault output group is nonzero at a time.
- status:
  - active=1 in ACTIVE.
  - current_fault = active type, else FAULT_NONE.
  - cycles_remaining = register value in ACTIVE, else 0.
  - injections_count is cleared only by rst_n; arm does not clear it.
- disarm: any state -> IDLE at the next edge. All fault outputs are 0 the following cycle. cycle_cnt and fired bits are held. disarm wins over a simultaneous arm.
- arm in ARMED or ACTIVE: restart, i.e. abort any current fault, cycle_cnt<=0, fired<=0, -> ARMED.
- rst_n mid-fault: all outputs drop asynchronously.

Test Plan:
- Slot0 = BACKPRESSURE, trigger 10, dur 5; arm at cnt 0 -> flt_backpressure high during cnt 11..15 (5 cycles); injections_count=1.
- Slot2 = RESET trigger 3 dur 0; slot1 = CORRUPT trigger 3 dur 2 mask 0xA5 -> corrupt mask 0xA5 at cnt 4..5, gap at cnt 6, flt_reset_rec single pulse at cnt 7; injections_count=2.
- Slot0 = BURST trigger 0 dur 4 param 16 -> burst_start pulse 1 cycle, burst_size=16 for 4 cycles; cycles_remaining reads 3,2,1,0.
- Slot0 = KILL dur 100; disarm at 20th active cycle -> flt_kill low next cycle, status.active=0; cfg_ready=1; a write with type 4'b1010 leaves the slot unchanged.
- Arm and disarm in the same cycle -> stays IDLE. Re-arm after a fault completes -> the same slot fires again; injections_count increments.
- cfg_valid while ARMED -> cfg_ready=0, slot unchanged.
